// File: rtl/decim_max_fifo.sv
// -----------------------------------------------------------------------------
// decim_max_fifo
//
// Peak decimator plus output FIFO, sitting after the sliding-average filter.
// The incoming 8-bit sample stream is cut into back-to-back windows of DECIM
// samples. The largest sample in each window is pushed into a DEPTH-entry
// FIFO. The FIFO drains to a consumer through a valid/ready handshake.
//
// Parameters
//   DECIM     window length in samples (>= 1)
//   DEPTH     FIFO depth in entries (power of 2, >= 2)
//   LW        width of level, derived from DEPTH (not meant to be overridden)
//
// Ports
//   clk       sole clock, rising edge
//   nrst      asynchronous active-low reset
//   din       filtered sample, unsigned, taken on every rising edge
//   out_data  FIFO head value, forced to 0 while the FIFO is empty
//   out_valid FIFO holds at least one entry
//   out_ready consumer takes the head on this edge (ignored when empty)
//   level     number of stored entries, 0..DEPTH
//   overflow  sticky flag: a window maximum was lost because the FIFO was full
//   clr_ovf   synchronous clear of overflow (a new drop on the same edge wins)
// -----------------------------------------------------------------------------
module decim_max_fifo #(
   parameter  int DECIM = 4,
   parameter  int DEPTH = 8,
   localparam int LW    = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          nrst,
   input  logic [7:0]    din,
   output logic [7:0]    out_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [LW-1:0] level,
   output logic          overflow,
   input  logic          clr_ovf
);

   // Pointer width for the circular buffer. Because DEPTH is a power of 2,
   // the pointers wrap from DEPTH-1 to 0 through plain binary overflow.
   localparam int PW = $clog2(DEPTH);

   // The phase counter keeps at least one bit so that DECIM=1 still has a
   // legal (constant zero) counter.
   localparam int PHW = (DECIM > 1) ? $clog2(DECIM) : 1;

   localparam logic [PHW-1:0] PH_LAST  = PHW'(DECIM - 1);
   localparam logic [LW-1:0]  LVL_FULL = LW'(DEPTH);

   logic [PHW-1:0] ph;
   logic [7:0]     mx;
   logic [7:0]     win_max;

   logic [7:0]     mem [DEPTH];
   logic [PW-1:0]  wr_ptr;
   logic [PW-1:0]  rd_ptr;
   logic [LW-1:0]  level_q;
   logic           ovf_q;

   logic           push;
   logic           pop;
   logic           full;
   logic           empty;
   logic           accept;
   logic           drop;

   // Phase counter. It runs freely out of reset, with no enable, so window
   // boundaries are fixed relative to the first edge after reset release.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         ph <= '0;
      end else if (ph == PH_LAST) begin
         ph <= '0;
      end else begin
         ph <= ph + PHW'(1);
      end
   end

   // Maximum of the window so far, including the current sample. At phase 0
   // the stored maximum belongs to the previous window, so only din counts.
   // This also makes DECIM=1 pass din straight through.
   always_comb begin
      win_max = din;
      if ((ph != '0) && (mx > din)) begin
         win_max = mx;
      end
   end

   // Running maximum register. It reloads from din at phase 0 because
   // win_max already ignores the old value there.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         mx <= '0;
      end else begin
         mx <= win_max;
      end
   end

   // Handshake and FIFO bookkeeping. A push into a full FIFO is accepted
   // when the head leaves on the same edge, so it is not a drop in that case.
   // A pop needs a non-empty FIFO, so out_ready has no effect while empty.
   assign push   = (ph == PH_LAST);
   assign full   = (level_q == LVL_FULL);
   assign empty  = (level_q == '0);
   assign pop    = !empty && out_ready;
   assign accept = push && (!full || pop);
   assign drop   = push && full && !pop;

   // Storage array. It has no reset because level_q decides which entries
   // are live, and out_data is forced to zero while the FIFO is empty.
   always_ff @(posedge clk) begin
      if (accept) begin
         mem[wr_ptr] <= win_max;
      end
   end

   // Write and read pointers advance by one per accepted push and per pop.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (accept) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
      end
   end

   // The occupancy counter tells full from empty without spending an extra
   // pointer bit. A push and a pop on the same edge cancel out.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         level_q <= '0;
      end else if (accept && !pop) begin
         level_q <= level_q + LW'(1);
      end else if (pop && !accept) begin
         level_q <= level_q - LW'(1);
      end
   end

   // Sticky overflow flag. Setting it takes priority over clearing it, so
   // a clear that lands on the edge of a drop does not hide that drop.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         ovf_q <= 1'b0;
      end else if (drop) begin
         ovf_q <= 1'b1;
      end else if (clr_ovf) begin
         ovf_q <= 1'b0;
      end
   end

   // Outputs depend only on registered state. A push into an empty FIFO
   // shows up after that edge, with no same-cycle fall-through.
   assign out_valid = !empty;
   assign out_data  = empty ? 8'd0 : mem[rd_ptr];
   assign level     = level_q;
   assign overflow  = ovf_q;

endmodule

// File: tb/tb_decim_max_fifo.sv
// -----------------------------------------------------------------------------
// tb_decim_max_fifo
//
// Bench for decim_max_fifo. It runs two instances side by side: the default
// build (DECIM=4, DEPTH=8) and a DECIM=1 build. Both share the clock and the
// reset. Each instance is compared after every edge against a queue-based
// model of window maxima and FIFO contents.
// -----------------------------------------------------------------------------
module tb_decim_max_fifo;

   localparam int DECIM = 4;
   localparam int DEPTH = 8;
   localparam int LW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          nrst = 1'b0;
   logic [7:0]    din = '0;
   logic          out_ready = 1'b0;
   logic          clr_ovf = 1'b0;
   logic [7:0]    out_data;
   logic          out_valid;
   logic [LW-1:0] level;
   logic          overflow;

   logic [7:0]    din1 = '0;
   logic          out_ready1 = 1'b0;
   logic          clr_ovf1 = 1'b0;
   logic [7:0]    out_data1;
   logic          out_valid1;
   logic [LW-1:0] level1;
   logic          overflow1;

   // Model state: samples of the open window, FIFO contents, sticky flags.
   logic [7:0] win[$];
   logic [7:0] q[$];
   logic       ovf;
   logic [7:0] q1[$];
   logic       ovf1;

   int n_assert = 0;
   int n_fail   = 0;

   decim_max_fifo #(.DECIM(DECIM), .DEPTH(DEPTH)) dut (
      .clk(clk), .nrst(nrst), .din(din),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .level(level), .overflow(overflow), .clr_ovf(clr_ovf)
   );

   decim_max_fifo #(.DECIM(1), .DEPTH(DEPTH)) dut1 (
      .clk(clk), .nrst(nrst), .din(din1),
      .out_data(out_data1), .out_valid(out_valid1), .out_ready(out_ready1),
      .level(level1), .overflow(overflow1), .clr_ovf(clr_ovf1)
   );

   always #5 clk = ~clk;

   // Single comparison point: counts the comparison and reports a mismatch.
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Compare the visible state of both instances with the models.
   task automatic checkOutput();
      chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
      chk("out_data",  32'(out_data),  (q.size() != 0) ? 32'(q[0]) : 32'd0);
      chk("level",     32'(level),     32'(q.size()));
      chk("overflow",  32'(overflow),  32'(ovf));
      chk("out_valid_d1", 32'(out_valid1), 32'(q1.size() != 0));
      chk("out_data_d1",  32'(out_data1),  (q1.size() != 0) ? 32'(q1[0]) : 32'd0);
      chk("level_d1",     32'(level1),     32'(q1.size()));
      chk("overflow_d1",  32'(overflow1),  32'(ovf1));
   endtask

   // Model of one rising edge, computed from the inputs held before the edge.
   task automatic modelEdge(input logic [7:0] d, input logic r, input logic c,
                            input logic [7:0] d1, input logic r1);
      logic       pushv;
      logic       dropv;
      logic [7:0] w;
      logic       popv;
      // DECIM=4 instance: collect samples, take the window maximum.
      popv  = (q.size() != 0) && r;
      pushv = 1'b0;
      dropv = 1'b0;
      w     = 8'd0;
      win.push_back(d);
      if (win.size() == DECIM) begin
         foreach (win[i]) if (win[i] > w) w = win[i];
         win.delete();
         pushv = 1'b1;
      end
      if (popv) void'(q.pop_front());
      if (pushv) begin
         if (q.size() < DEPTH) q.push_back(w);
         else dropv = 1'b1;
      end
      if (dropv) ovf = 1'b1;
      else if (c) ovf = 1'b0;
      // DECIM=1 instance: every sample is its own window.
      popv  = (q1.size() != 0) && r1;
      dropv = 1'b0;
      if (popv) void'(q1.pop_front());
      if (q1.size() < DEPTH) q1.push_back(d1);
      else dropv = 1'b1;
      if (dropv) ovf1 = 1'b1;
      else if (clr_ovf1) ovf1 = 1'b0;
   endtask

   // Drive one sample, clock it in, update the model, check after the edge.
   task automatic applyStimulus(input logic [7:0] d, input logic r, input logic c,
                                input logic [7:0] d1, input logic r1);
      din        = d;
      out_ready  = r;
      clr_ovf    = c;
      din1       = d1;
      out_ready1 = r1;
      @(posedge clk);
      modelEdge(d, r, c, d1, r1);
      #1;
      checkOutput();
   endtask

   // Assert reset away from an edge, check async clear, release at negedge.
   task automatic doReset();
      nrst = 1'b0;
      #1;
      win.delete();
      q.delete();
      q1.delete();
      ovf  = 1'b0;
      ovf1 = 1'b0;
      checkOutput();
      @(posedge clk);
      #1;
      checkOutput();
      @(negedge clk);
      nrst = 1'b1;
   endtask

   initial begin
      logic [7:0] d;
      logic [7:0] m;
      int         pos;

      ovf  = 1'b0;
      ovf1 = 1'b0;
      $display("[TB] start");

      // Reset state before any clock edge.
      #2;
      checkOutput();
      @(negedge clk);
      nrst = 1'b1;

      // Ramp 0..15 with out_ready high. The DECIM=1 build sees 5,6,7 first.
      for (int i = 0; i < 16; i++) begin
         applyStimulus(8'(i), 1'b1, 1'b0, (i < 3) ? 8'(5 + i) : 8'($urandom), 1'b1);
         if (i < 3) chk("d1_passthru", 32'(out_data1), 32'(5 + i));
         if (i == 2) chk("ramp_not_yet_valid", 32'(out_valid), 32'd0);
         if (i == 3) chk("ramp_first_max", 32'(out_data), 32'd3);
      end

      // Window restart and unsigned compare on a large value.
      applyStimulus(8'd9,   1'b1, 1'b0, 8'($urandom), 1'b1);
      applyStimulus(8'd5,   1'b1, 1'b0, 8'($urandom), 1'b1);
      applyStimulus(8'd2,   1'b1, 1'b0, 8'($urandom), 1'b1);
      applyStimulus(8'd1,   1'b1, 1'b0, 8'($urandom), 1'b1);
      chk("winmax_first", 32'(out_data), 32'd9);
      applyStimulus(8'd0,   1'b1, 1'b0, 8'($urandom), 1'b1);
      applyStimulus(8'd0,   1'b1, 1'b0, 8'($urandom), 1'b1);
      applyStimulus(8'd200, 1'b1, 1'b0, 8'($urandom), 1'b1);
      applyStimulus(8'd3,   1'b1, 1'b0, 8'($urandom), 1'b1);
      chk("winmax_second", 32'(out_data), 32'd200);

      // Overflow: 9 windows with maxima 1..9 and no consumer. A clear that
      // lands on the dropping edge must not win.
      doReset();
      for (int w = 1; w <= 9; w++) begin
         pos = int'($urandom_range(0, 3));
         for (int s = 0; s < 4; s++) begin
            d = (s == pos) ? 8'(w) : 8'($urandom_range(0, w - 1));
            applyStimulus(d, 1'b0, (w == 9) && (s == 3), 8'($urandom), 1'($urandom));
         end
         if (w == 8) chk("ovf_level_full", 32'(level), 32'd8);
      end
      chk("ovf_level_after_drop", 32'(level), 32'd8);
      chk("ovf_set_over_clear", 32'(overflow), 32'd1);
      chk("ovf_head_oldest", 32'(out_data), 32'd1);
      for (int i = 0; i < 12; i++) begin
         applyStimulus(8'd0, 1'b1, 1'b0, 8'($urandom), 1'($urandom));
         if (i == 0) chk("ovf_second_head", 32'(out_data), 32'd2);
      end
      chk("ovf_sticky", 32'(overflow), 32'd1);
      applyStimulus(8'd0, 1'b1, 1'b1, 8'($urandom), 1'b1);
      chk("ovf_cleared", 32'(overflow), 32'd0);

      // Full FIFO with a simultaneous push and pop on the push edge.
      doReset();
      for (int i = 0; i < 8 * DECIM; i++) begin
         applyStimulus(8'($urandom), 1'b0, 1'b0, 8'($urandom), 1'b1);
      end
      chk("full_level", 32'(level), 32'd8);
      for (int s = 0; s < DECIM; s++) begin
         applyStimulus(8'($urandom), s == DECIM - 1, 1'b0, 8'($urandom), 1'b1);
      end
      chk("full_pushpop_level", 32'(level), 32'd8);
      chk("full_pushpop_ovf", 32'(overflow), 32'd0);
      for (int i = 0; i < 12; i++) begin
         applyStimulus(8'($urandom), 1'b1, 1'b0, 8'($urandom), 1'b1);
      end

      // Randomized traffic on both instances.
      for (int i = 0; i < 300; i++) begin
         applyStimulus(8'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0),
                       8'($urandom), 1'($urandom));
      end

      // Reset mid-window with three entries stored.
      doReset();
      for (int i = 0; i < 3 * DECIM + 2; i++) begin
         applyStimulus(8'($urandom), 1'b0, 1'b0, 8'($urandom), 1'b1);
      end
      chk("pre_reset_level", 32'(level), 32'd3);
      doReset();
      m = 8'd0;
      for (int s = 0; s < DECIM; s++) begin
         d = 8'($urandom);
         if (d > m) m = d;
         applyStimulus(d, 1'b0, 1'b0, 8'($urandom), 1'b1);
      end
      chk("fresh_window_level", 32'(level), 32'd1);
      chk("fresh_window_max", 32'(out_data), 32'(m));

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
